interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Collects trap and interrupt events (NMI, ECALL, EBREAK, timer, external IRQ lines), applies masking and fixed priority, and issues a single stable request (`interruptF`, `interSel`, `intNum`) to the vector-address generator and the pipeline redirect logic. It sits between the event sources (decode stage, timer, external pins) and the fetch-redirect path. It holds the request until the core accepts it, then tracks the handler until `mret`.

## Interface
- `NUM_IRQ`, default 8: number of external interrupt lines.
- `IDW`, default 3: width of `intNum`; must satisfy 2^IDW >= NUM_IRQ.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `nmi_i` input 1: non-maskable interrupt, rising-edge sensitive.
- `ecall_i` input 1: one-cycle pulse from decode.
- `ebreak_i` input 1: one-cycle pulse from decode.
- `tmr_i` input 1: timer interrupt, level; the source holds it until the handler clears it.
- `irq_i` input NUM_IRQ: external interrupts, level.
- `mie` input 1: global enable for TMR and INT.
- `tmr_en` input 1: timer enable.
- `irq_mask` input NUM_IRQ: per-line enable; 1 = enabled.
- `take` input 1: core accepts the current request this cycle.
- `mret` input 1: handler return.
- `interruptF` output 1: request valid.
- `interSel` output 3: cause code. NMI 3'd0, ECALL 3'd1, EBREAK 3'd2, TMR 3'd3, INT 3'd4.
- `intNum` output IDW: external line index; 0 unless `interSel` = INT.
- `in_service` output 1: a handler is active.

## Operation
- Sticky pending bits:
  - `nmi_p` is set on the rising edge of `nmi_i` (rise = `nmi_i & ~nmi_d`).
  - `ecall_p` is set by an `ecall_i` pulse.
  - `ebreak_p` is set by an `ebreak_i` pulse.
  - A set in the same cycle as a clear wins over the clear.
- Level sources (`tmr_i`, `irq_i`) are not latched. They are sampled live.
- Eligible sets, computed combinationally:
  - NMI = `nmi_p` | rise.
  - EBREAK = `ebreak_p` | `ebreak_i`.
  - ECALL = `ecall_p` | `ecall_i`.
  - TMR = `tmr_i & tmr_en & mie`.
  - INT[i] = `irq_i[i] & irq_mask[i] & mie`.
- Priority, highest first: NMI > EBREAK > ECALL > TMR > INT. Among INT lines, the lowest index wins.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE, any eligible source: register the winner into `interSel`/`intNum`, set `interruptF`, go to REQ.
  - IDLE, nothing eligible: stay in IDLE.
  - REQ: outputs are frozen. A later higher-priority event does not replace the request; it stays pending.
  - REQ, `take` = 1: clear the winner's sticky bit (NMI/ECALL/EBREAK only), drop `interruptF`, set `in_service`, go to SERVICE.
  - SERVICE: no new request is issued. New events keep accumulating in their pending bits.
  - SERVICE, `mret` = 1: clear `in_service`, go to IDLE.
- Ignored inputs:
  - `take` is ignored outside REQ.
  - `mret` is ignored outside SERVICE.
- Level-source withdrawal during REQ is not supported. The frozen request stays until `take`.
- Cause-code outputs hold their last values after `take`. `interruptF` qualifies them.

## Timing
- Reset values:
  - `interruptF` = 0, `interSel` = 3'd0, `intNum` = 0, `in_service` = 0.
  - State = IDLE; all sticky bits = 0.
  - `nmi_d` = 1, so an `nmi_i` already high at reset release is not an edge.
- Request latency: a source that becomes eligible in cycle N while in IDLE gives `interruptF` = 1 in cycle N+1. This applies to pulse and level sources alike.
- Handshake: `take` sampled high in cycle M (state REQ) gives `interruptF` = 0 and `in_service` = 1 in cycle M+1.
- Return: `mret` in cycle K (state SERVICE) gives `in_service` = 0 in cycle K+1 (state IDLE).
  - If a source is eligible in cycle K+1, `interruptF` = 1 in cycle K+2.
  - Minimum gap between requests: 1 IDLE cycle.
- Same-cycle events:
  - ECALL and EBREAK pulses in the same cycle: EBREAK is issued first; `ecall_p` stays set and is issued after the following `mret`.
  - `take` and a new pulse of the same cause in one cycle: the sticky bit remains set.
- Reset asserted in any state: the next cycle shows the reset values. Pending events and the in-service context are discarded.

## Test plan
- Reset, then `irq_i` = 8'b0010_0100, `irq_mask` = 8'hFF, `mie` = 1:
  - Next cycle: `interruptF` = 1, `interSel` = 3'd4, `intNum` = 2.
  - After `take`, `in_service` = 1.
- `ecall_i` and `ebreak_i` pulse together in IDLE:
  - Request `interSel` = 3'd2 issued; `take`, then `mret`.
  - Second request `interSel` = 3'd1 appears 2 cycles after `mret`.
- In REQ holding TMR (3'd3), pulse `nmi_i`:
  - Outputs stay 3'd3 until `take`.
  - After `mret`, NMI (3'd0) is issued.
- `mie` = 0 with `tmr_i` = 1 and `irq_i` = 8'hFF: no request.
  - Then pulse `nmi_i`: `interSel` = 3'd0 is issued despite `mie` = 0.
- `nmi_i` held high across reset release: no request.
  - Drop `nmi_i` and raise it again: request 3'd0 one cycle after the rise.
- `rst` asserted while in SERVICE with `ecall_p` pending:
  - Next cycle all outputs are 0.
  - No request follows until a new event arrives.

Source files
------------

// File: rtl/interrupt_controller.sv
// Trap/interrupt arbiter: latches NMI/ECALL/EBREAK events, masks level sources,
// picks a fixed-priority winner and holds a single request until take, then tracks the handler until mret.
module interrupt_controller #(
  parameter int NUM_IRQ = 8,
  parameter int IDW     = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nmi_i,
  input  logic               ecall_i,
  input  logic               ebreak_i,
  input  logic               tmr_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               mie,
  input  logic               tmr_en,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               take,
  input  logic               mret,
  output logic               interruptF,
  output logic [2:0]         interSel,
  output logic [IDW-1:0]     intNum,
  output logic               in_service
);

  localparam logic [2:0] CauseNmi    = 3'd0;
  localparam logic [2:0] CauseEcall  = 3'd1;
  localparam logic [2:0] CauseEbreak = 3'd2;
  localparam logic [2:0] CauseTmr    = 3'd3;
  localparam logic [2:0] CauseInt    = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             nmiDly_q;
  logic             nmiP_q, nmiP_d;
  logic             ecallP_q, ecallP_d;
  logic             ebreakP_q, ebreakP_d;
  logic             interruptF_q, interruptF_d;
  logic [2:0]       interSel_q, interSel_d;
  logic [IDW-1:0]   intNum_q, intNum_d;
  logic             inService_q, inService_d;

  logic               nmiRise;
  logic               nmiElig, ecallElig, ebreakElig, tmrElig;
  logic [NUM_IRQ-1:0] intElig;
  logic [IDW-1:0]     intIdx;
  logic               anyElig;
  logic [2:0]         winSel;
  logic               takeNow;

  assign nmiRise    = nmi_i & ~nmiDly_q;
  assign nmiElig    = nmiP_q | nmiRise;
  assign ebreakElig = ebreakP_q | ebreak_i;
  assign ecallElig  = ecallP_q | ecall_i;
  assign tmrElig    = tmr_i & tmr_en & mie;
  assign intElig    = irq_i & irq_mask & {NUM_IRQ{mie}};
  assign anyElig    = nmiElig | ebreakElig | ecallElig | tmrElig | (|intElig);
  assign takeNow    = (state_q == REQ) & take;

  // Scanning downwards leaves the lowest eligible line index in intIdx.
  always_comb begin
    intIdx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (intElig[i]) intIdx = IDW'(i);
    end
  end

  always_comb begin
    if (nmiElig)         winSel = CauseNmi;
    else if (ebreakElig) winSel = CauseEbreak;
    else if (ecallElig)  winSel = CauseEcall;
    else if (tmrElig)    winSel = CauseTmr;
    else                 winSel = CauseInt;
  end

  // Sticky bits: a new event in the same cycle as the take-clear keeps the bit set.
  always_comb begin
    nmiP_d    = (nmiP_q    & ~(takeNow & (interSel_q == CauseNmi)))    | nmiRise;
    ecallP_d  = (ecallP_q  & ~(takeNow & (interSel_q == CauseEcall)))  | ecall_i;
    ebreakP_d = (ebreakP_q & ~(takeNow & (interSel_q == CauseEbreak))) | ebreak_i;
  end

  // Request FSM; cause outputs are only rewritten when a new request is issued from IDLE.
  always_comb begin
    state_d      = state_q;
    interruptF_d = interruptF_q;
    interSel_d   = interSel_q;
    intNum_d     = intNum_q;
    inService_d  = inService_q;
    case (state_q)
      IDLE: begin
        if (anyElig) begin
          interruptF_d = 1'b1;
          interSel_d   = winSel;
          intNum_d     = (winSel == CauseInt) ? intIdx : '0;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (take) begin
          interruptF_d = 1'b0;
          inService_d  = 1'b1;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (mret) begin
          inService_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // nmiDly_q resets high so an NMI line already asserted at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      nmiDly_q     <= 1'b1;
      nmiP_q       <= 1'b0;
      ecallP_q     <= 1'b0;
      ebreakP_q    <= 1'b0;
      interruptF_q <= 1'b0;
      interSel_q   <= 3'd0;
      intNum_q     <= '0;
      inService_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      nmiDly_q     <= nmi_i;
      nmiP_q       <= nmiP_d;
      ecallP_q     <= ecallP_d;
      ebreakP_q    <= ebreakP_d;
      interruptF_q <= interruptF_d;
      interSel_q   <= interSel_d;
      intNum_q     <= intNum_d;
      inService_q  <= inService_d;
    end
  end

  assign interruptF = interruptF_q;
  assign interSel   = interSel_q;
  assign intNum     = intNum_q;
  assign in_service = inService_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios against fixed values, then random traffic
// compared cycle by cycle with a behavioural model of the request/handler protocol.
module tb_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       nmi_i, ecall_i, ebreak_i, tmr_i;
  logic [7:0] irq_i;
  logic       mie, tmr_en;
  logic [7:0] irq_mask;
  logic       take, mret;
  logic       interruptF;
  logic [2:0] interSel;
  logic [2:0] intNum;
  logic       in_service;

  int nChecks = 0;
  int nFails  = 0;

  // model state: phase 0 = waiting, 1 = request raised, 2 = handler running
  int       mPhase;
  bit       mPendNmi, mPendEcall, mPendEbreak, mPrevNmi;
  bit       expF, expSvc;
  bit [2:0] expSel, expNum;

  interrupt_controller #(.NUM_IRQ(8), .IDW(3)) dut (
    .clk(clk), .rst(rst), .nmi_i(nmi_i), .ecall_i(ecall_i), .ebreak_i(ebreak_i),
    .tmr_i(tmr_i), .irq_i(irq_i), .mie(mie), .tmr_en(tmr_en), .irq_mask(irq_mask),
    .take(take), .mret(mret), .interruptF(interruptF), .interSel(interSel),
    .intNum(intNum), .in_service(in_service)
  );

  always #5 clk = ~clk;

  // Model of one rising edge using the inputs currently applied.
  task automatic modelStep();
    bit rise;
    bit found;
    int winCause;
    int winLine;
    bit [4:0] want;
    int prio [5];
    prio = '{0, 2, 1, 3, 4};
    if (rst) begin
      mPhase = 0; mPendNmi = 0; mPendEcall = 0; mPendEbreak = 0; mPrevNmi = 1;
      expF = 0; expSel = 0; expNum = 0; expSvc = 0;
      return;
    end
    rise = nmi_i && !mPrevNmi;
    want[0] = mPendNmi || rise;
    want[1] = mPendEcall || ecall_i;
    want[2] = mPendEbreak || ebreak_i;
    want[3] = tmr_i && tmr_en && mie;
    want[4] = mie && ((irq_i & irq_mask) != 0);
    winLine = 0;
    found = 0;
    for (int k = 7; k >= 0; k--) if (mie && irq_i[k] && irq_mask[k]) winLine = k;
    winCause = 0;
    foreach (prio[p]) if (!found && want[prio[p]]) begin found = 1; winCause = prio[p]; end
    if (mPhase == 1 && take) begin
      if (expSel == 0) mPendNmi = 0;
      if (expSel == 1) mPendEcall = 0;
      if (expSel == 2) mPendEbreak = 0;
    end
    if (rise) mPendNmi = 1;
    if (ecall_i) mPendEcall = 1;
    if (ebreak_i) mPendEbreak = 1;
    if (mPhase == 0 && found) begin
      expF = 1; expSel = 3'(winCause); expNum = (winCause == 4) ? 3'(winLine) : 3'd0; mPhase = 1;
    end else if (mPhase == 1 && take) begin
      expF = 0; expSvc = 1; mPhase = 2;
    end else if (mPhase == 2 && mret) begin
      expSvc = 0; mPhase = 0;
    end
    mPrevNmi = nmi_i;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input bit n, input bit ec, input bit eb, input bit tk, input bit mr);
    nmi_i = n; ecall_i = ec; ebreak_i = eb; take = tk; mret = mr;
    tick();
    ecall_i = 0; ebreak_i = 0; take = 0; mret = 0;
  endtask

  task automatic test_reset();
    rst = 1; nmi_i = 0; ecall_i = 0; ebreak_i = 0; tmr_i = 0; irq_i = 0;
    mie = 1; tmr_en = 1; irq_mask = 8'hFF; take = 0; mret = 0;
    tick(); tick();
    rst = 0;
    nChecks++;
    if ({interruptF, interSel, intNum, in_service} !== 8'd0) begin
      nFails++;
      $display("[TB] FAIL reset_values got F=%b sel=%0d num=%0d svc=%b want all 0", interruptF, interSel, intNum, in_service);
    end
  endtask

  task automatic test_irq_priority();
    irq_i = 8'b0010_0100;
    tick();
    nChecks++;
    if ({interruptF, interSel, intNum} !== {1'b1, 3'd4, 3'd2}) begin
      nFails++;
      $display("[TB] FAIL irq_request got F=%b sel=%0d num=%0d want F=1 sel=4 num=2", interruptF, interSel, intNum);
    end
    applyStimulus(0, 0, 0, 1, 0);
    irq_i = 0;
    nChecks++;
    if ({interruptF, in_service} !== 2'b01) begin
      nFails++;
      $display("[TB] FAIL irq_take got F=%b svc=%b want F=0 svc=1", interruptF, in_service);
    end
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    nChecks++;
    if ({interruptF, in_service} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL irq_return got F=%b svc=%b want 0 0", interruptF, in_service);
    end
  endtask

  task automatic test_ecall_ebreak();
    applyStimulus(0, 1, 1, 0, 0);
    nChecks++;
    if ({interruptF, interSel} !== {1'b1, 3'd2}) begin
      nFails++;
      $display("[TB] FAIL ebreak_first got F=%b sel=%0d want F=1 sel=2", interruptF, interSel);
    end
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    nChecks++;
    if ({interruptF, in_service} !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL ecall_gap got F=%b svc=%b want 0 0", interruptF, in_service);
    end
    tick();
    nChecks++;
    if ({interruptF, interSel} !== {1'b1, 3'd1}) begin
      nFails++;
      $display("[TB] FAIL ecall_second got F=%b sel=%0d want F=1 sel=1", interruptF, interSel);
    end
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic test_req_freeze();
    tmr_i = 1;
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    nChecks++;
    if ({interruptF, interSel} !== {1'b1, 3'd3}) begin
      nFails++;
      $display("[TB] FAIL req_frozen got F=%b sel=%0d want F=1 sel=3", interruptF, interSel);
    end
    applyStimulus(0, 0, 0, 1, 0);
    tmr_i = 0;
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    nChecks++;
    if ({interruptF, interSel} !== {1'b1, 3'd0}) begin
      nFails++;
      $display("[TB] FAIL nmi_after_mret got F=%b sel=%0d want F=1 sel=0", interruptF, interSel);
    end
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic test_mie_mask();
    mie = 0; tmr_i = 1; irq_i = 8'hFF;
    tick(); tick();
    nChecks++;
    if (interruptF !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL mie_masked got F=%b want F=0", interruptF);
    end
    applyStimulus(1, 0, 0, 0, 0);
    nChecks++;
    if ({interruptF, interSel} !== {1'b1, 3'd0}) begin
      nFails++;
      $display("[TB] FAIL nmi_unmaskable got F=%b sel=%0d want F=1 sel=0", interruptF, interSel);
    end
    applyStimulus(0, 0, 0, 1, 0);
    tmr_i = 0; irq_i = 0;
    applyStimulus(0, 0, 0, 0, 1);
    mie = 1;
  endtask

  task automatic test_nmi_reset();
    nmi_i = 1; rst = 1;
    tick(); tick();
    rst = 0;
    tick(); tick();
    nChecks++;
    if (interruptF !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL nmi_held_reset got F=%b want F=0", interruptF);
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    nChecks++;
    if ({interruptF, interSel} !== {1'b1, 3'd0}) begin
      nFails++;
      $display("[TB] FAIL nmi_rise got F=%b sel=%0d want F=1 sel=0", interruptF, interSel);
    end
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_service();
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    rst = 1;
    tick();
    rst = 0;
    nChecks++;
    if ({interruptF, interSel, intNum, in_service} !== 8'd0) begin
      nFails++;
      $display("[TB] FAIL reset_in_service got F=%b sel=%0d num=%0d svc=%b want all 0", interruptF, interSel, intNum, in_service);
    end
    tick(); tick(); tick();
    nChecks++;
    if (interruptF !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL pending_discarded got F=%b want F=0", interruptF);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    nChecks++;
    if ({interruptF, in_service} !== 2'b01) begin
      nFails++;
      $display("[TB] FAIL b2b_take got F=%b svc=%b want F=0 svc=1", interruptF, in_service);
    end
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    nChecks++;
    if ({interruptF, interSel} !== {1'b1, 3'd1}) begin
      nFails++;
      $display("[TB] FAIL b2b_resticky got F=%b sel=%0d want F=1 sel=1", interruptF, interSel);
    end
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst      = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) == 0) nmi_i = ~nmi_i;
      ecall_i  = ($urandom_range(0, 14) == 0);
      ebreak_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) tmr_i = ~tmr_i;
      irq_i    = 8'($urandom & $urandom & $urandom);
      mie      = ($urandom_range(0, 4) != 0);
      tmr_en   = ($urandom_range(0, 3) != 0);
      irq_mask = 8'($urandom);
      take     = ($urandom_range(0, 2) == 0);
      mret     = ($urandom_range(0, 2) == 0);
      tick();
      nChecks++;
      if ({interruptF, interSel, intNum, in_service} !== {expF, expSel, expNum, expSvc}) begin
        nFails++;
        $display("[TB] FAIL random_cycle_%0d got F=%b sel=%0d num=%0d svc=%b want F=%b sel=%0d num=%0d svc=%b",
                 cyc, interruptF, interSel, intNum, in_service, expF, expSel, expNum, expSvc);
      end
    end
    rst = 0; take = 0; mret = 0; ecall_i = 0; ebreak_i = 0;
  endtask

  initial begin
    test_reset();
    test_irq_priority();
    test_ecall_ebreak();
    test_req_freeze();
    test_mie_mask();
    test_nmi_reset();
    test_reset_service();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
